four_way_link_merge: RTL and testbench
======================================

Name: four_way_link_merge

Overview:
- Four-input, one-output link merge stage with a round-robin arbiter and an output FIFO.
- Sits directly downstream of the four-way link switch fan-out. Each of its inputs consumes one switch output port, for example output_link_k of four separate switches targeting the same destination.
- Grants at most one input per cycle, buffers the accepted packet, and presents it on a single sender link toward the next router hop or PE input channel.

Parameters:
- BUFFER_DEPTH, 2, number of packet entries in the output FIFO. Power of two, >= 2.

Ports:
- clk  input  1  clock
- n_reset  input  1  asynchronous, active-low reset
- enable  input  1  when 0, no new packets are accepted; the FIFO still drains
- input_mask  input  4  bit k=1 allows input_link_k to participate in arbitration
- input_link_0..input_link_3  link_if.receiver  req/ack/packet  upstream links
- output_link  link_if.sender  req/ack/packet  merged downstream link
- occupancy  output  $clog2(BUFFER_DEPTH)+1  current FIFO entry count

Behaviour:
- Link transfer rule: a packet moves on a rising clk edge where req=1 and ack=1.
  - Sender holds req and packet stable until that edge.
  - ack may depend combinationally on req.
- Reset (n_reset=0, asynchronous):
  - count=0, rd_ptr=0, wr_ptr=0, rr_ptr=0.
  - All input acks=0, output_link.req=0, output_link.packet=NULL_PACKET, occupancy=0.
  - Reset mid-transfer discards all buffered packets and clears in-flight acks immediately.
- Eligibility: input k is eligible when input_link_k.req=1 AND input_mask[k]=1 AND enable=1 AND count<BUFFER_DEPTH.
- Arbitration (combinational, same cycle):
  - Scan k = rr_ptr, rr_ptr+1, ... (mod 4); grant the first eligible input.
  - ack of the granted input = 1; all other acks = 0. At most one ack is high in any cycle.
  - No eligible input: all acks 0.
- Push on the edge with a grant:
  - FIFO[wr_ptr] <= granted packet; wr_ptr wraps mod BUFFER_DEPTH.
  - rr_ptr <= (granted index + 1) mod 4.
  - Without a grant, rr_ptr is unchanged.
- Output side:
  - output_link.req = (count != 0).
  - output_link.packet = FIFO[rd_ptr] when count != 0, else NULL_PACKET.
  - Pop on edge with output_link.req & output_link.ack; rd_ptr wraps mod BUFFER_DEPTH.
- Latency: a packet accepted at edge N drives output_link.req=1 and appears on output_link.packet in the cycle after edge N (1 cycle). There is no bypass path.
- Simultaneous push and pop: count unchanged. This is legal for any count below BUFFER_DEPTH.
- Full (count=BUFFER_DEPTH):
  - All acks 0, even when a pop occurs in the same cycle; full does not admit same-cycle refill.
  - Acks resume in the cycle after count drops.
- Empty: output req=0 and packet=NULL_PACKET. A pop cannot occur.
- enable or input_mask change: takes effect in the same cycle, combinationally on acks. Buffered packets are never dropped.
- Ordering:
  - Packets from one input leave in acceptance order.
  - Inter-input order equals grant order.
- Fairness: with all four inputs continuously eligible, grants rotate 0,1,2,3,0,... No input waits more than 3 grants.
- occupancy = count, registered.

Test Plan:
- Reset/idle: assert n_reset=0 mid-stream with count=2 -> same-cycle output req=0, packet=NULL_PACKET, acks 0, occupancy=0; after release with no input reqs, all stay idle.
- Single stream: input 2 sends 0x11, 0x22, 0x33 with output ack tied 1 -> each packet appears 1 cycle after its accept, in order; occupancy stays <=1; input 2 acked every cycle.
- Round-robin: all four reqs held high with output ack=1 -> grant order 0,1,2,3,0,1; rr_ptr after the 6th grant = 2.
- Backpressure/full: output ack=0, inputs 0 and 1 requesting, BUFFER_DEPTH=2 -> two accepts (0 then 1), then acks 0 with occupancy=2. Raise output ack for one cycle -> one pop; acks stay 0 that cycle and one new accept follows the next cycle.
- Mask/enable: input_mask=4'b1011 with all reqs high -> input 2 never acked. Drop enable with count=2 and output ack=1 -> no new accepts, two pops, then output req=0.
- Concurrent push/pop: count=1, input 3 req and output ack both 1 -> one accept and one pop on the same edge; occupancy stays 1; the packet from input 3 is output next.

Source files
------------

// File: rtl/four_way_link_merge_if.sv
// Point-to-point req/ack link carrying one packet per transfer.
// A transfer completes on the rising edge where req and ack are both high.
interface link_if #(parameter int PW = 8);
   logic          req;
   logic          ack;
   logic [PW-1:0] packet;

   modport sender   (output req, output packet, input ack);
   modport receiver (input req, input packet, output ack);
endinterface

// File: rtl/four_way_link_merge.sv
// Four-input merge: round-robin grant into an output FIFO; packet visible 1 cycle after accept.
// Backpressure: no acks while the FIFO is full (even on a same-cycle pop); FIFO always drains.
module four_way_link_merge #(
   parameter int BUFFER_DEPTH = 2,
   parameter int PW           = 8
) (
   input  logic                            clk,
   input  logic                            n_reset,
   input  logic                            enable,
   input  logic [3:0]                      input_mask,
   link_if.receiver                        input_link_0,
   link_if.receiver                        input_link_1,
   link_if.receiver                        input_link_2,
   link_if.receiver                        input_link_3,
   link_if.sender                          output_link,
   output logic [$clog2(BUFFER_DEPTH):0]   occupancy
);
   localparam int AW = $clog2(BUFFER_DEPTH);
   localparam int CW = AW + 1;

   logic [PW-1:0] mem [BUFFER_DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [1:0]    rr_ptr;

   logic [3:0]    req_v;
   logic [PW-1:0] pkt_v [4];
   logic [3:0]    elig;
   logic          full;
   logic          grant_vld;
   logic [1:0]    grant_idx;
   logic [1:0]    scan_idx;
   logic          push;
   logic          pop;

   assign req_v    = {input_link_3.req, input_link_2.req, input_link_1.req, input_link_0.req};
   assign pkt_v[0] = input_link_0.packet;
   assign pkt_v[1] = input_link_1.packet;
   assign pkt_v[2] = input_link_2.packet;
   assign pkt_v[3] = input_link_3.packet;

   assign full = (count == CW'(BUFFER_DEPTH));
   // Gating with n_reset drops acks the instant reset asserts, not at the next edge.
   assign elig = req_v & input_mask & {4{enable & n_reset & ~full}};

   always_comb begin
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      scan_idx  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         scan_idx = rr_ptr + 2'(i);
         if (!grant_vld && elig[scan_idx]) begin
            grant_vld = 1'b1;
            grant_idx = scan_idx;
         end
      end
   end

   assign input_link_0.ack = grant_vld && (grant_idx == 2'd0);
   assign input_link_1.ack = grant_vld && (grant_idx == 2'd1);
   assign input_link_2.ack = grant_vld && (grant_idx == 2'd2);
   assign input_link_3.ack = grant_vld && (grant_idx == 2'd3);

   assign output_link.req    = (count != '0);
   assign output_link.packet = (count != '0) ? mem[rd_ptr] : '0;

   assign push = grant_vld;
   assign pop  = (count != '0) && output_link.ack;

   always_comb begin
      count_nxt = count;
      if (push && !pop)
         count_nxt = count + CW'(1);
      else if (!push && pop)
         count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         rr_ptr    <= 2'd0;
         occupancy <= '0;
      end else begin
         count     <= count_nxt;
         occupancy <= count_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
            rr_ptr <= grant_idx + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= pkt_v[grant_idx];
   end
endmodule

// File: tb/tb_four_way_link_merge.sv
// Randomized and directed checks of four_way_link_merge against a queue-based reference model.
module tb_four_way_link_merge;
   localparam int DEPTH = 2;

   logic       clk = 1'b0;
   logic       n_reset;
   logic       enable;
   logic [3:0] input_mask;
   logic [1:0] occupancy;

   logic [3:0] in_req;
   logic [7:0] in_pkt [4];
   logic       out_ack;

   link_if #(.PW(8)) l0 ();
   link_if #(.PW(8)) l1 ();
   link_if #(.PW(8)) l2 ();
   link_if #(.PW(8)) l3 ();
   link_if #(.PW(8)) lo ();

   assign l0.req = in_req[0];  assign l0.packet = in_pkt[0];
   assign l1.req = in_req[1];  assign l1.packet = in_pkt[1];
   assign l2.req = in_req[2];  assign l2.packet = in_pkt[2];
   assign l3.req = in_req[3];  assign l3.packet = in_pkt[3];
   assign lo.ack = out_ack;

   four_way_link_merge #(.BUFFER_DEPTH(DEPTH), .PW(8)) dut (
      .clk          (clk),
      .n_reset      (n_reset),
      .enable       (enable),
      .input_mask   (input_mask),
      .input_link_0 (l0),
      .input_link_1 (l1),
      .input_link_2 (l2),
      .input_link_3 (l3),
      .output_link  (lo),
      .occupancy    (occupancy)
   );

   always #5 clk = ~clk;

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] q[$];
   int         rr = 0;
   int         last_g = -1;
   logic [3:0] last_dut_ack;
   int         ord [6] = '{0, 1, 2, 3, 0, 1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] dut_acks();
      return {l3.ack, l2.ack, l1.ack, l0.ack};
   endfunction

   // Called just after a falling edge with inputs already set; returns after the next falling edge.
   task automatic step();
      int         g;
      logic [3:0] ea;
      logic [7:0] epkt;
      logic       do_pop;
      #1;
      g = -1;
      for (int i = 0; i < 4; i++) begin
         int k;
         k = (rr + i) % 4;
         if (g < 0 && in_req[k] && input_mask[k] && enable && n_reset && q.size() < DEPTH)
            g = k;
      end
      ea   = (g >= 0) ? 4'(1 << g) : 4'b0000;
      epkt = (q.size() != 0) ? q[0] : 8'h00;
      last_dut_ack = dut_acks();
      chk("ack", 32'(last_dut_ack), 32'(ea));
      chk("out_req", 32'(lo.req), 32'(q.size() != 0));
      chk("out_pkt", 32'(lo.packet), 32'(epkt));
      chk("occupancy", 32'(occupancy), 32'(q.size()));
      last_g = g;
      do_pop = (q.size() != 0) && out_ack;
      @(posedge clk);
      if (do_pop) void'(q.pop_front());
      if (g >= 0) begin
         q.push_back(in_pkt[g]);
         rr = (g + 1) % 4;
      end
      @(negedge clk);
   endtask

   task automatic next_pkt_on_accept();
      if (last_g >= 0) in_pkt[last_g] = 8'($urandom);
   endtask

   task automatic do_reset();
      n_reset = 1'b0;
      #1;
      q.delete();
      rr = 0;
      @(negedge clk);
      n_reset = 1'b1;
   endtask

   initial begin
      n_reset    = 1'b0;
      enable     = 1'b1;
      input_mask = 4'hF;
      in_req     = 4'b0000;
      out_ack    = 1'b0;
      for (int k = 0; k < 4; k++) in_pkt[k] = 8'(k + 1);
      @(negedge clk);
      @(negedge clk);
      in_req = 4'b1111;
      #1;
      chk("rst_ack", 32'(dut_acks()), 32'h0);
      chk("rst_req", 32'(lo.req), 32'h0);
      chk("rst_pkt", 32'(lo.packet), 32'h0);
      chk("rst_occ", 32'(occupancy), 32'h0);
      in_req = 4'b0000;
      @(negedge clk);
      n_reset = 1'b1;

      // single stream from input 2
      out_ack = 1'b1;
      in_req = 4'b0100;
      in_pkt[2] = 8'h11; step();
      in_pkt[2] = 8'h22; step();
      in_pkt[2] = 8'h33; step();
      in_req = 4'b0000;
      step(); step();

      // round robin across all four inputs
      do_reset();
      in_req = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rr_order", 32'(last_dut_ack), 32'(1 << ord[i]));
         next_pkt_on_accept();
      end
      step();
      chk("rr_after6", 32'(last_dut_ack), 32'h4);
      in_req = 4'b0000;
      step(); step(); step();

      // backpressure until full, then a single pop
      do_reset();
      out_ack = 1'b0;
      in_req  = 4'b0011;
      step(); next_pkt_on_accept();
      step(); next_pkt_on_accept();
      step();
      #1;
      chk("full_occ", 32'(occupancy), 32'd2);
      @(negedge clk);
      out_ack = 1'b1;
      step();
      chk("full_pop_noack", 32'(last_dut_ack), 32'h0);
      out_ack = 1'b0;
      step();
      chk("refill_ack", 32'(last_dut_ack), 32'h1);
      in_req  = 4'b0000;
      out_ack = 1'b1;
      step(); step(); step();

      // mask excludes input 2
      input_mask = 4'b1011;
      in_req     = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         step();
         chk("mask_no2", 32'(last_dut_ack[2]), 32'h0);
         next_pkt_on_accept();
      end
      input_mask = 4'hF;

      // enable drop with two buffered packets
      out_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin step(); next_pkt_on_accept(); end
      enable  = 1'b0;
      out_ack = 1'b1;
      step(); step(); step();
      #1;
      chk("en_drained", 32'(lo.req), 32'h0);
      @(negedge clk);
      enable = 1'b1;
      in_req = 4'b0000;
      step();

      // concurrent push and pop at count 1
      out_ack = 1'b0;
      in_req  = 4'b1000;
      in_pkt[3] = 8'hA5;
      step();
      in_pkt[3] = 8'h5A;
      out_ack   = 1'b1;
      step();
      #1;
      chk("cc_occ", 32'(occupancy), 32'd1);
      chk("cc_pkt", 32'(lo.packet), 32'h5A);
      @(negedge clk);
      in_req = 4'b0000;
      step(); step();

      // reset mid-stream with two buffered packets
      out_ack = 1'b0;
      in_req  = 4'b0011;
      step(); next_pkt_on_accept();
      step(); next_pkt_on_accept();
      n_reset = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(dut_acks()), 32'h0);
      chk("mid_rst_req", 32'(lo.req), 32'h0);
      chk("mid_rst_pkt", 32'(lo.packet), 32'h0);
      chk("mid_rst_occ", 32'(occupancy), 32'h0);
      q.delete();
      rr = 0;
      in_req = 4'b0000;
      @(negedge clk);
      n_reset = 1'b1;
      step(); step(); step();

      // randomized traffic with sender hold rule honoured
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 4; k++) begin
            if (!in_req[k] || last_g == k) begin
               in_req[k] = 1'($urandom % 2);
               in_pkt[k] = 8'($urandom);
            end
         end
         out_ack = 1'($urandom % 3 != 0);
         enable  = 1'($urandom % 8 != 0);
         if ($urandom % 16 == 0) input_mask = 4'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
